dsp_io_bank: RTL and testbench

DSP_IO_BANK -- requirements
Module: dsp_io_bank

---
 rtl/dsp_pkg.sv | 23 ++
 rtl/dsp_io_saturate.sv | 49 ++++
 rtl/dsp_io_bank.sv | 180 ++++++++++++++++++
 tb/tb_dsp_io_bank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types and defaults for the DSP audio I/O bank.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package dsp_pkg;

    // Frame handshake states: waiting for a frame, or DSP busy on one.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dsp_state_t;

    localparam int DEF_NUM_CH     = 8;
    localparam int DEF_IO_WIDTH   = 24;
    localparam int DEF_DATA_WIDTH = 36;
    localparam int DEF_HEADROOM   = 4;

    // Left shift that places the codec sample MSB just below the guard bits
    // of the DSP word. The same amount is used for the right shift on writes.
    function automatic int shift_amt(input int data_w, input int io_w, input int headroom);
        return data_w - io_w - headroom;
    endfunction

endpackage

// File: rtl/dsp_io_saturate.sv
// Reduces a signed word to a narrower signed word (clamp or two's-complement wrap).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Build option: DSP_IO_SATURATE_EN selects clamping; undefined selects wrap with clipped tied low.
module dsp_io_saturate #(
    parameter int IN_W  = 36,
    parameter int OUT_W = 24
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             clipped
);

`ifdef DSP_IO_SATURATE_EN
    localparam int EXT = IN_W - OUT_W;

    logic sign;
    logic fits;

    assign sign = din[IN_W-1];
    // Value fits when every bit from the output sign bit upward matches the input sign.
    assign fits = (din[IN_W-1:OUT_W-1] == {(EXT + 1){sign}});

    // Pass through when representable, otherwise pin to the rail on the sign's side.
    always_comb begin
        dout    = din[OUT_W-1:0];
        clipped = 1'b0;
        if (!fits) begin
            clipped = 1'b1;
            if (sign) begin
                dout = {1'b1, {(OUT_W - 1){1'b0}}};
            end else begin
                dout = {1'b0, {(OUT_W - 1){1'b1}}};
            end
        end
    end
`else
    // Upper bits are simply discarded in wrap mode.
    logic unused_upper;
    assign unused_upper = ^din[IN_W-1:OUT_W];

    // Keep the low bits; overflow wraps and is never flagged.
    always_comb begin
        dout    = din[OUT_W-1:0];
        clipped = 1'b0;
    end
`endif

endmodule

// File: rtl/dsp_io_bank.sv
// Double-banked codec <-> DSP sample exchange with frame handshake and sticky status.
// Latency: reads return one cycle after rd_en; writes reach audio_outputs at the next frame_tick.
// Backpressure: none; reads/writes accepted every cycle, a frame_tick while busy flags overrun.
// Build option: DSP_IO_SATURATE_EN clamps written samples and enables sat_err; otherwise wrap.
module dsp_io_bank
    import dsp_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int IO_WIDTH   = DEF_IO_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int HEADROOM   = DEF_HEADROOM,
    parameter int AW         = $clog2(NUM_CH) + 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               frame_tick,
    input  logic [NUM_CH-1:0][IO_WIDTH-1:0]    audio_inputs,
    output logic [NUM_CH-1:0][IO_WIDTH-1:0]    audio_outputs,
    input  logic [AW-1:0]                      rd_addr,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              rd_data,
    input  logic [AW-1:0]                      wr_addr,
    input  logic                               wr_en,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               dsp_start,
    input  logic                               dsp_done,
    output logic                               overrun,
    output logic                               addr_err,
    output logic                               sat_err,
    input  logic                               clr_status
);

    localparam int SHIFT = shift_amt(DATA_WIDTH, IO_WIDTH, HEADROOM);

    // Sample storage: snapshot of the codec inputs and the DSP-written staging bank.
    logic [NUM_CH-1:0][IO_WIDTH-1:0] in_bank;
    logic [NUM_CH-1:0][IO_WIDTH-1:0] stage_bank;

    // Address decode. NUM_CH is a power of two, so the top address bit alone
    // marks an out-of-range channel.
    logic rd_ok;
    logic rd_bad;
    logic wr_ok;
    logic wr_bad;

    assign rd_ok  = rd_en & ~rd_addr[AW-1];
    assign rd_bad = rd_en &  rd_addr[AW-1];
    assign wr_ok  = wr_en & ~wr_addr[AW-1];
    assign wr_bad = wr_en &  wr_addr[AW-1];

    // Read path: sign-extend the stored sample and align it under the guard bits.
    logic signed [IO_WIDTH-1:0]   rd_sample;
    logic signed [DATA_WIDTH-1:0] rd_wide;

    assign rd_sample = in_bank[rd_addr[AW-2:0]];
    assign rd_wide   = DATA_WIDTH'(rd_sample) <<< SHIFT;

    // Write path: drop the fractional LSBs, then reduce to codec width.
    logic signed [DATA_WIDTH-1:0] wr_shift;
    logic [IO_WIDTH-1:0]          wr_sample;
    logic                         wr_clip;

    assign wr_shift = $signed(wr_data) >>> SHIFT;

    dsp_io_saturate #(
        .IN_W  (DATA_WIDTH),
        .OUT_W (IO_WIDTH)
    ) u_sat (
        .din     (wr_shift),
        .dout    (wr_sample),
        .clipped (wr_clip)
    );

    // Frame handshake FSM signals.
    dsp_state_t state;
    dsp_state_t state_nxt;
    logic       start_nxt;
    logic       ovr_set;

    // Next state: a tick starts a frame from IDLE; a done (even with a
    // coincident tick) ends the current frame; a tick alone while busy is an overrun.
    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        ovr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_nxt = ST_RUN;
                    start_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (dsp_done) begin
                    if (frame_tick) begin
                        start_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (frame_tick) begin
                    ovr_set = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register and the registered one-cycle start pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            dsp_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            dsp_start <= start_nxt;
        end
    end

    // Frame boundary: capture codec inputs and publish the staging bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_bank       <= '0;
            audio_outputs <= '0;
        end else if (frame_tick) begin
            in_bank       <= audio_inputs;
            audio_outputs <= stage_bank;
        end
    end

    // DSP writes into staging; a write on a tick cycle misses this frame's copy
    // because the copy above samples the pre-write contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_bank <= '0;
        end else if (wr_ok) begin
            stage_bank[wr_addr[AW-2:0]] <= wr_sample;
        end
    end

    // DSP read port: registered, holds its value when idle, zero for bad addresses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_ok) begin
            rd_data <= rd_wide;
        end else if (rd_bad) begin
            rd_data <= '0;
        end
    end

    // Sticky status: a set event in the same cycle outranks clr_status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun  <= 1'b0;
            addr_err <= 1'b0;
            sat_err  <= 1'b0;
        end else begin
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end

            if (rd_bad || wr_bad) begin
                addr_err <= 1'b1;
            end else if (clr_status) begin
                addr_err <= 1'b0;
            end

            if (wr_ok && wr_clip) begin
                sat_err <= 1'b1;
            end else if (clr_status) begin
                sat_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_io_bank.sv
// Scoreboard bench for dsp_io_bank: directed stimulus pushes expectations, a monitor checks them.
// Latency: reads checked one cycle after rd_en, outputs and dsp_start on each frame_tick edge.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_dsp_io_bank;

    localparam int NCH = 8;
    localparam int IOW = 24;
    localparam int DW  = 36;
    localparam int AW  = 4;

`ifdef DSP_IO_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [NCH-1:0][IOW-1:0] bank_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           frame_tick = 1'b0;
    bank_t          audio_inputs = '0;
    bank_t          audio_outputs;
    logic [AW-1:0]  rd_addr = '0;
    logic           rd_en = 1'b0;
    logic [DW-1:0]  rd_data;
    logic [AW-1:0]  wr_addr = '0;
    logic           wr_en = 1'b0;
    logic [DW-1:0]  wr_data = '0;
    logic           dsp_start;
    logic           dsp_done = 1'b0;
    logic           overrun;
    logic           addr_err;
    logic           sat_err;
    logic           clr_status = 1'b0;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;

    bank_t         model_stage = '0;
    bank_t         ao_q[$];
    logic          st_q[$];
    logic [DW-1:0] rd_q[$];

    dsp_io_bank #(
        .NUM_CH     (NCH),
        .IO_WIDTH   (IOW),
        .DATA_WIDTH (DW),
        .HEADROOM   (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_tick    (frame_tick),
        .audio_inputs  (audio_inputs),
        .audio_outputs (audio_outputs),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .wr_addr       (wr_addr),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .dsp_start     (dsp_start),
        .dsp_done      (dsp_done),
        .overrun       (overrun),
        .addr_err      (addr_err),
        .sat_err       (sat_err),
        .clr_status    (clr_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at a falling edge, let the next rising edge sample, release.
    task automatic step(input bit tk, input bit dn, input bit re, input logic [AW-1:0] ra,
                        input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [IOW-1:0] w_exp, input bit clr, input bit exp_start,
                        input logic [DW-1:0] rd_exp);
        @(negedge clk);
        frame_tick = tk;
        dsp_done   = dn;
        rd_en      = re;
        rd_addr    = ra;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        clr_status = clr;
        if (tk) begin
            ao_q.push_back(model_stage);
            st_q.push_back(exp_start);
        end
        if (re) rd_q.push_back(rd_exp);
        if (we && (wa < AW'(NCH))) model_stage[wa[2:0]] = w_exp;
        @(negedge clk);
        frame_tick = 1'b0;
        dsp_done   = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        clr_status = 1'b0;
    endtask

    task automatic do_tick(input bit dn, input bit exp_start);
        step(1'b1, dn, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0, exp_start, '0);
    endtask

    task automatic do_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        step(1'b0, 1'b0, 1'b1, a, 1'b0, '0, '0, '0, 1'b0, 1'b0, exp);
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [IOW-1:0] exp);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, a, d, exp, 1'b0, 1'b0, '0);
    endtask

    task automatic do_clr();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
    endtask

    task automatic do_done();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_audio_outputs"}, 64'(audio_outputs == '0), 64'd1);
        check({tag, "_rd_data"},   64'(rd_data),   64'd0);
        check({tag, "_dsp_start"}, 64'(dsp_start), 64'd0);
        check({tag, "_overrun"},   64'(overrun),   64'd0);
        check({tag, "_addr_err"},  64'(addr_err),  64'd0);
        check({tag, "_sat_err"},   64'(sat_err),   64'd0);
    endtask

    // Monitor: inputs change only on falling edges, so just after a rising edge
    // they still show what that edge sampled, next to the outputs it produced.
    initial begin
        bank_t         exp_bank;
        logic          exp_st;
        logic [DW-1:0] exp_rd;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                if (dsp_start) start_cnt++;
                if (rd_en) begin
                    if (rd_q.size() == 0) begin
                        check("rd_unexpected", 64'd1, 64'd0);
                    end else begin
                        exp_rd = rd_q.pop_front();
                        check("rd_data", 64'(rd_data), 64'(exp_rd));
                    end
                end
                if (frame_tick) begin
                    if (ao_q.size() == 0 || st_q.size() == 0) begin
                        check("tick_unexpected", 64'd1, 64'd0);
                    end else begin
                        exp_bank = ao_q.pop_front();
                        exp_st   = st_q.pop_front();
                        for (int c = 0; c < NCH; c++) begin
                            check($sformatf("audio_outputs_ch%0d", c),
                                  64'(audio_outputs[c]), 64'(exp_bank[c]));
                        end
                        check("dsp_start", 64'(dsp_start), 64'(exp_st));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int starts_before;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Capture inputs on the first frame; all-zero staging goes out.
        audio_inputs[3] = 24'h800000;
        audio_inputs[0] = 24'h000001;
        audio_inputs[7] = 24'h7FFFFF;
        audio_inputs[1] = 24'h123456;
        do_tick(1'b0, 1'b1);
        check("start_cnt_first", 64'(start_cnt), 64'd1);

        // Reads: sign extension and alignment 8 bits up.
        do_rd(4'd3, 36'hF80000000);
        do_rd(4'd0, 36'h000000100);
        do_rd(4'd7, 36'h07FFFFF00);
        do_rd(4'd1, 36'h012345600);
        repeat (2) @(negedge clk);
        check("rd_hold", 64'(rd_data), 64'h012345600);
        do_done();

        // Writes. 36'h07FFFFFF0 shifted right by 8 is 0x7FFFFF, which fits, so no clipping.
        do_wr(4'd5, 36'h07FFFFFF0, 24'h7FFFFF);
        check("sat_err_fit", 64'(sat_err), 64'd0);
        do_wr(4'd2, 36'h000012300, 24'h000123);
        do_wr(4'd4, 36'hFFFFFFF00, 24'hFFFFFF);
        // Shifted to 0x07FFFFFF: clamps to max or wraps to all ones.
        do_wr(4'd6, 36'h7FFFFFF00, SAT ? 24'h7FFFFF : 24'hFFFFFF);
        // Shifted to -2^27: clamps to min or wraps to zero.
        do_wr(4'd0, 36'h800000000, SAT ? 24'h800000 : 24'h000000);
        check("sat_err_clip", 64'(sat_err), 64'(SAT));

        // Tick with a coincident write: ch1 must not appear until the next tick.
        starts_before = start_cnt;
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 4'd1, 36'h000000500, 24'h000005, 1'b0, 1'b1, '0);
        check("overrun_first_tick", 64'(overrun), 64'd0);

        // Second tick without done: overrun, no new start, banks still update.
        do_tick(1'b0, 1'b0);
        check("overrun_set", 64'(overrun), 64'd1);
        check("single_start", 64'(start_cnt - starts_before), 64'd1);

        // Clear coinciding with another overrun keeps overrun; sat_err clears.
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
        check("overrun_priority", 64'(overrun), 64'd1);
        check("sat_err_cleared", 64'(sat_err), 64'd0);
        do_clr();
        check("overrun_cleared", 64'(overrun), 64'd0);

        // Out-of-range channels.
        do_rd(4'd8, 36'd0);
        check("addr_err_rd", 64'(addr_err), 64'd1);
        do_clr();
        check("addr_err_cleared", 64'(addr_err), 64'd0);
        do_wr(4'd9, 36'h0FFFFFF00, 24'h0);
        check("addr_err_wr", 64'(addr_err), 64'd1);
        do_clr();

        // Done and tick together while running: no overrun, fresh start.
        starts_before = start_cnt;
        do_tick(1'b1, 1'b1);
        check("overrun_done_tick", 64'(overrun), 64'd0);
        check("start_done_tick", 64'(start_cnt - starts_before), 64'd1);

        // Reset mid-frame after writes: everything returns to zero.
        do_wr(4'd3, 36'h000000A00, 24'h00000A);
        do_rd(4'd3, 36'hF80000000);
        do_wr(4'd12, 36'h0, 24'h0);
        check("addr_err_pre_reset", 64'(addr_err), 64'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_stage = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_rd(4'd3, 36'd0);
        starts_before = start_cnt;
        do_tick(1'b0, 1'b1);
        check("start_after_reset", 64'(start_cnt - starts_before), 64'd1);
        do_rd(4'd3, 36'hF80000000);
        repeat (3) @(negedge clk);

        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check("ao_q_drained", 64'(ao_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
